// File: rtl/chase_led_gen_if.sv
// Control and LED-drive bundle for chase_led_gen.
// The controller drives stop/mode/divisor, and the generator drives out/dir/tick.
interface chase_led_gen_if #(
   parameter int WIDTH = 16,
   parameter int DIV_W = 24
);
   logic             stop;
   logic [1:0]       mode;
   logic [DIV_W-1:0] divisor;
   logic [WIDTH-1:0] out;
   logic             dir;
   logic             tick;

   modport master (output stop, mode, divisor, input out, dir, tick);
   modport slave  (input stop, mode, divisor, output out, dir, tick);
endinterface

// File: rtl/chase_led_gen.sv
// Chasing-LED pattern generator with a step prescaler.
// It tracks a single lead position and drives a one-hot or thermometer LED pattern.
// Position, direction and pattern all update together on each prescaler step.
module chase_led_gen #(
   parameter int WIDTH = 16,
   parameter int DIV_W = 24
) (
   input  logic           clk,
   input  logic           reset,
   chase_led_gen_if.slave bus
);
   localparam int POS_W = $clog2(WIDTH);
   localparam logic [POS_W-1:0] POS_MAX = POS_W'(WIDTH - 1);
   localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);
   localparam logic [DIV_W-1:0] CNT_ONE = DIV_W'(1);

   typedef enum logic [1:0] {
      MODE_BOUNCE = 2'b00,
      MODE_ROT_L  = 2'b01,
      MODE_ROT_R  = 2'b10,
      MODE_BAR    = 2'b11
   } mode_e;

   mode_e            mode;
   logic             step_en;
   logic [POS_W-1:0] pos, pos_nxt;
   logic             dir_r, dir_nxt;
   logic [DIV_W-1:0] cnt;
   logic             tick_r;
   logic [WIDTH-1:0] out_r, out_nxt;

   assign mode    = mode_e'(bus.mode);
   // A step is due once the counter has reached the divisor.
   // Using >= means a divisor lowered below cnt fires the step immediately.
   assign step_en = !bus.stop && (cnt >= bus.divisor);

   // Next lead position and direction for the selected run mode.
   always_comb begin
      // NOTE: defaults first so every path assigns both outputs; no latch is inferred.
      pos_nxt = pos;
      dir_nxt = dir_r;
      unique case (mode)
         MODE_BOUNCE: begin
            if (!dir_r) begin
               if (pos == POS_MAX) begin
                  pos_nxt = POS_MAX - POS_ONE;
                  dir_nxt = 1'b1;
               end else begin
                  pos_nxt = pos + POS_ONE;
               end
            end else begin
               if (pos == '0) begin
                  pos_nxt = POS_ONE;
                  dir_nxt = 1'b0;
               end else begin
                  pos_nxt = pos - POS_ONE;
               end
            end
         end
         MODE_ROT_R: begin
            dir_nxt = 1'b1;
            pos_nxt = (pos == '0) ? POS_MAX : pos - POS_ONE;
         end
         // MODE_ROT_L and MODE_BAR both climb toward the MSB and wrap to 0.
         default: begin
            dir_nxt = 1'b0;
            pos_nxt = (pos == POS_MAX) ? '0 : pos + POS_ONE;
         end
      endcase
   end

   // Pattern decode of the next position: one-hot, or thermometer in bar mode.
   always_comb begin
      out_nxt = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (mode == MODE_BAR) out_nxt[i] = (i <= int'(pos_nxt));
         else                  out_nxt[i] = (i == int'(pos_nxt));
      end
   end

   // Prescaler, position/direction and registered outputs.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         pos    <= '0;
         dir_r  <= 1'b0;
         cnt    <= '0;
         tick_r <= 1'b0;
         out_r  <= WIDTH'(1);
      end else begin
         tick_r <= step_en;
         if (step_en) begin
            cnt   <= '0;
            pos   <= pos_nxt;
            dir_r <= dir_nxt;
            out_r <= out_nxt;
         end else if (!bus.stop) begin
            cnt <= cnt + CNT_ONE;
         end
      end
   end

   assign bus.out  = out_r;
   assign bus.dir  = dir_r;
   assign bus.tick = tick_r;
endmodule

// File: tb/tb_chase_led_gen.sv
// Self-checking bench for chase_led_gen (WIDTH=16).
// Directed scenarios use literal expectations.
// A random phase runs while a behavioural model is compared against the DUT every cycle.
module tb_chase_led_gen;
   localparam int WIDTH = 16;
   localparam int DIV_W = 24;

   logic clk = 1'b0;
   logic reset;
   int   n_tests = 0;
   int   n_fail  = 0;
   bit   cmp_en  = 1'b0;

   chase_led_gen_if #(.WIDTH(WIDTH), .DIV_W(DIV_W)) bus ();

   chase_led_gen #(.WIDTH(WIDTH), .DIV_W(DIV_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct { int pos; bit dir; } mstate_t;

   function automatic mstate_t model_next(int pos, bit dir, logic [1:0] mode);
      mstate_t s;
      s.pos = pos;
      s.dir = dir;
      case (mode)
         2'b00: begin
            if (!dir) begin
               if (pos == WIDTH - 1) begin s.pos = WIDTH - 2; s.dir = 1; end
               else s.pos = pos + 1;
            end else begin
               if (pos == 0) begin s.pos = 1; s.dir = 0; end
               else s.pos = pos - 1;
            end
         end
         2'b10: begin s.dir = 1; s.pos = (pos + WIDTH - 1) % WIDTH; end
         default: begin s.dir = 0; s.pos = (pos + 1) % WIDTH; end
      endcase
      return s;
   endfunction

   function automatic logic [WIDTH-1:0] model_pattern(int pos, logic [1:0] mode);
      longint unsigned v;
      if (mode == 2'b11) v = (64'd1 << (pos + 1)) - 64'd1;
      else               v = 64'd1 << pos;
      return WIDTH'(v);
   endfunction

   int               m_pos;
   bit               m_dir;
   longint unsigned  m_wait;   // cycles counted toward the current step
   bit               m_tick;
   logic [WIDTH-1:0] m_out;

   always @(posedge clk) begin
      if (reset) begin
         m_pos  <= 0;
         m_dir  <= 0;
         m_wait <= 0;
         m_tick <= 0;
         m_out  <= WIDTH'(1);
      end else if (!bus.stop && m_wait >= longint'(bus.divisor)) begin
         m_tick <= 1;
         m_wait <= 0;
         m_pos  <= model_next(m_pos, m_dir, bus.mode).pos;
         m_dir  <= model_next(m_pos, m_dir, bus.mode).dir;
         m_out  <= model_pattern(model_next(m_pos, m_dir, bus.mode).pos, bus.mode);
      end else begin
         m_tick <= 0;
         if (!bus.stop) m_wait <= m_wait + 1;
      end
   end

   // Every-cycle comparison of the DUT against the model, away from the active edge.
   always @(negedge clk) begin
      if (cmp_en) begin
         check("model_out", 64'(bus.out), 64'(m_out));
         check("model_dir", 64'(bus.dir), 64'(m_dir));
         check("model_tick", 64'(bus.tick), 64'(m_tick));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick_clk(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic reset_dut(input logic [1:0] mode, input int div);
      reset       = 1'b1;
      bus.stop    = 1'b0;
      bus.mode    = mode;
      bus.divisor = DIV_W'(div);
      tick_clk(2);
      reset = 1'b0;
   endtask

   initial begin
      logic [WIDTH-1:0] exp_out;
      int ticks;

      reset = 1'b1;
      bus.stop = 1'b0;
      bus.mode = 2'b00;
      bus.divisor = '0;
      tick_clk(1);
      cmp_en = 1'b1;

      // Bounce, divisor 0.
      reset_dut(2'b00, 0);
      check("reset_out", 64'(bus.out), 64'h0001);
      check("reset_dir", 64'(bus.dir), 64'd0);
      check("reset_tick", 64'(bus.tick), 64'd0);
      tick_clk(15);
      check("bounce_top_out", 64'(bus.out), 64'h8000);
      check("bounce_top_dir", 64'(bus.dir), 64'd0);
      check("model_pin_top", 64'(m_out), 64'h8000);
      tick_clk(1);
      check("bounce_turn_out", 64'(bus.out), 64'h4000);
      check("bounce_turn_dir", 64'(bus.dir), 64'd1);
      tick_clk(14);
      check("bounce_bottom_out", 64'(bus.out), 64'h0001);
      check("bounce_bottom_dir", 64'(bus.dir), 64'd1);
      tick_clk(1);
      check("bounce_return_out", 64'(bus.out), 64'h0002);
      check("bounce_return_dir", 64'(bus.dir), 64'd0);

      // Rotate left, divisor 3: one tick in four cycles, wrapping on the 16th step.
      reset_dut(2'b01, 3);
      ticks = 0;
      for (int i = 1; i <= 64; i++) begin
         tick_clk(1);
         if (bus.tick) ticks++;
         check("rotl_tick", 64'(bus.tick), 64'((i % 4) == 0));
         exp_out = WIDTH'(64'd1 << ((i / 4) % 16));
         check("rotl_out", 64'(bus.out), 64'(exp_out));
      end
      check("rotl_tick_count", 64'(ticks), 64'd16);
      check("rotl_wrap_out", 64'(bus.out), 64'h0001);

      // Rotate right from reset.
      reset_dut(2'b10, 0);
      tick_clk(1);
      check("rotr_first_out", 64'(bus.out), 64'h8000);
      check("rotr_first_dir", 64'(bus.dir), 64'd1);
      tick_clk(1);
      check("rotr_second_out", 64'(bus.out), 64'h4000);

      // Bar fill, divisor 0.
      reset_dut(2'b11, 0);
      tick_clk(1);
      check("bar_1", 64'(bus.out), 64'h0003);
      tick_clk(1);
      check("bar_2", 64'(bus.out), 64'h0007);
      tick_clk(13);
      check("bar_full", 64'(bus.out), 64'hFFFF);
      check("model_pin_bar", 64'(m_out), 64'hFFFF);
      check("bar_dir", 64'(bus.dir), 64'd0);
      tick_clk(1);
      check("bar_empty", 64'(bus.out), 64'h0001);

      // Stop raised at cnt=5 with divisor 7.
      reset_dut(2'b01, 7);
      tick_clk(5);
      bus.stop = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick_clk(1);
         check("stop_hold_out", 64'(bus.out), 64'h0001);
         check("stop_no_tick", 64'(bus.tick), 64'd0);
      end
      bus.stop = 1'b0;
      tick_clk(2);
      check("stop_resume_wait", 64'(bus.out), 64'h0001);
      tick_clk(1);
      check("stop_resume_out", 64'(bus.out), 64'h0002);
      check("stop_resume_tick", 64'(bus.tick), 64'd1);

      // Reset while stop is high and out=0x0400.
      reset_dut(2'b01, 0);
      tick_clk(10);
      check("pre_reset_out", 64'(bus.out), 64'h0400);
      bus.stop = 1'b1;
      reset = 1'b1;
      tick_clk(1);
      check("reset_stop_out", 64'(bus.out), 64'h0001);
      check("reset_stop_tick", 64'(bus.tick), 64'd0);
      reset = 1'b0;
      bus.stop = 1'b0;

      // Divisor lowered below cnt fires the step on the next edge.
      reset_dut(2'b01, 9);
      tick_clk(6);
      check("div_drop_before", 64'(bus.out), 64'h0001);
      bus.divisor = DIV_W'(2);
      tick_clk(1);
      check("div_drop_out", 64'(bus.out), 64'h0002);
      check("div_drop_tick", 64'(bus.tick), 64'd1);

      // Randomised run checked by the model.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 19) == 0) bus.mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 29) == 0) bus.divisor = DIV_W'($urandom_range(0, 4));
         if ($urandom_range(0, 14) == 0) bus.stop = ~bus.stop;
         reset = ($urandom_range(0, 299) == 0);
         tick_clk(1);
      end
      reset = 1'b0;
      tick_clk(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/chase_led_gen.md
# chase_led_gen

Parametrised chasing-LED pattern generator that drives a WIDTH-bit LED bank from a single lit position with a built-in step prescaler. It supports four run modes (bounce, rotate-left, rotate-right, bar-fill), a stop/freeze input and a runtime step divisor. It sits between the board clock domain and the LED pins, and a higher-level controller selects mode and speed through switch inputs.

## Interface
Parameters:
- WIDTH, 16, number of LEDs; legal range 2..64.
- DIV_W, 24, width of the step-divisor input and the internal prescaler counter.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- stop  in  1  freeze: while high, the prescaler, position and direction all hold.
- mode  in  2  00 bounce, 01 rotate left (toward MSB), 10 rotate right (toward LSB), 11 bar fill.
- divisor  in  DIV_W  step period minus one, in clk cycles (0 = one step per cycle).
- out  out  WIDTH  LED drive pattern.
- dir  out  1  current travel direction: 0 = toward MSB, 1 = toward LSB.
- tick  out  1  one-cycle pulse, high in the first cycle a new pattern is on out.

## Operation
- State:
  - pos: $clog2(WIDTH) bits, index of the lead LED.
  - dir_r: 1 bit.
  - cnt: DIV_W-bit prescaler counter.
  - tick_r: 1 bit.
- step_en = !stop && (cnt >= divisor), combinational.
- When step_en is high, cnt loads 0 and pos/dir_r advance. Otherwise, if stop is low, cnt increments; if stop is high, cnt holds.
- out decode, registered from pos:
  - Modes 00, 01, 10: one-hot, out = 1 << pos.
  - Mode 11: thermometer, out[i] = (i <= pos).
- Advance rules on step_en:
  - Mode 00 (bounce):
    - If dir_r = 0 and pos < WIDTH-1: pos + 1.
    - If dir_r = 0 and pos = WIDTH-1: dir_r <= 1 and pos <= WIDTH-2 in the same step (no dwell at the end).
    - Mirror rule at pos = 0 while dir_r = 1: dir_r <= 0 and pos <= 1.
    - Full period is 2*(WIDTH-1) steps.
  - Mode 01: dir_r forced 0; pos + 1, wrapping WIDTH-1 -> 0.
  - Mode 10: dir_r forced 1; pos - 1, wrapping 0 -> WIDTH-1.
  - Mode 11: dir_r forced 0; pos + 1, wrapping WIDTH-1 -> 0 (the bar empties to a single LED).
- Mode changes:
  - Sampled only on step_en; pos is never reset by a mode change.
  - On entry to bounce, dir_r keeps its last value.
- dir output = dir_r.
- tick = tick_r, where tick_r <= step_en.
- Reset values:
  - pos = 0, dir_r = 0, cnt = 0, tick_r = 0.
  - out = {{WIDTH-1{1'b0}},1'b1} in every mode.
  - dir = 0, tick = 0.
- Reset takes priority over stop and step_en.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Latency: the edge where step_en = 1 updates pos, dir_r, out and tick_r together, so out and tick change one cycle after the qualifying cnt value.
- Step spacing: divisor+1 cycles while stop is low and divisor is constant.
- Divisor decreased below the current cnt: the step fires on the next cycle (>= compare). cnt never overruns.
- Divisor increased: the current period stretches to the new value.
- stop:
  - Rising: the edge on which stop is high performs no step. cnt holds its current value.
  - Falling: counting resumes from the held cnt, so the remaining cycles of the period are preserved.
- Reset mid-operation, including while stop is high: the next edge returns to the reset values, and the first step occurs divisor+1 cycles after reset deasserts.
- Mode and divisor are assumed synchronous to clk. Switch synchronisation is done upstream.

## Test plan
- WIDTH=16, mode=00, divisor=0, reset then release:
  - out 0x0001 -> 0x0002 ... 0x8000 after 15 steps with dir=0.
  - Next step 0x4000 with dir=1.
  - 0x0001 reached after 30 steps, then 0x0002 with dir=0.
- divisor=3, mode=01:
  - tick high exactly 1 cycle in every 4.
  - out advances on the tick cycles only.
  - 0x8000 -> 0x0001 wraps on the 16th step.
- mode=10 from reset:
  - First step 0x0001 -> 0x8000, dir=1.
  - Next step 0x4000.
- mode=11, divisor=0:
  - out 0x0001, 0x0003, 0x0007 ... 0xFFFF, then 0x0001.
  - 16-step period, dir stays 0.
- divisor=7, stop raised at cnt=5 for 10 cycles:
  - out, dir and cnt hold; no tick.
  - After release, the step occurs 3 cycles later.
- Edge cases:
  - Reset asserted while stop=1 and out=0x0400: next cycle out=0x0001, tick=0.
  - With cnt=6, divisor changed 9 -> 2: a step fires on the next edge.
